// File: rtl/ysyx_22050710_id_stage_pkg.sv
// Shared decode definitions for the ysyx_22050710 pipeline.
// Provides the RV64 opcode and branch funct3 encodings, the inter-stage bus
// widths, and helpers that say which source registers an opcode reads.
package ysyx_22050710_defs;

    localparam int unsigned INST_WD         = 32;
    localparam int unsigned PC_WD           = 64;
    localparam int unsigned XLEN            = 64;
    localparam int unsigned FS_TO_DS_BUS_WD = INST_WD + PC_WD;
    localparam int unsigned DS_TO_ES_BUS_WD = 5 + 3 * XLEN + INST_WD + PC_WD;
    localparam int unsigned BR_BUS_WD       = PC_WD + 1;

    typedef enum logic [6:0] {
        OPC_LUI      = 7'b0110111,
        OPC_AUIPC    = 7'b0010111,
        OPC_JAL      = 7'b1101111,
        OPC_JALR     = 7'b1100111,
        OPC_BRANCH   = 7'b1100011,
        OPC_LOAD     = 7'b0000011,
        OPC_STORE    = 7'b0100011,
        OPC_OP_IMM   = 7'b0010011,
        OPC_OP       = 7'b0110011,
        OPC_OP_IMM32 = 7'b0011011,
        OPC_OP32     = 7'b0111011
    } opcode_e;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } br_funct3_e;

    function automatic logic rs1_used(input logic [6:0] opcode);
        return !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
    endfunction

    function automatic logic rs2_used(input logic [6:0] opcode);
        return opcode == OPC_BRANCH || opcode == OPC_STORE ||
               opcode == OPC_OP     || opcode == OPC_OP32;
    endfunction

endpackage

// File: rtl/ysyx_22050710_id_stage_imm_gen.sv
// Immediate generator: maps an instruction to its sign-extended immediate.
//   inst : instruction word
//   imm  : I/S/B/U/J immediate by opcode, sign-extended to XLEN; 0 otherwise
module ysyx_22050710_imm_gen
    import ysyx_22050710_defs::*;
(
    input  logic [INST_WD-1:0] inst,
    output logic [XLEN-1:0]    imm
);

    always_comb begin
        imm = '0;
        case (inst[6:0])
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32:
                imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
            OPC_STORE:
                imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH:
                imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
            OPC_JAL:
                imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_22050710_id_stage.sv
// Decode stage. Holds one {inst, pc} bundle from fetch, reads the register
// file, builds the immediate, interlocks on RAW hazards against EX/MEM/WB,
// resolves branches/jumps and drives the branch bus back to fetch.
//   i_clk, i_rst            : clock, async active-high reset
//   i_fs_to_ds_valid/_bus   : fetch bundle {inst, pc} and its valid
//   o_ds_allowin            : this stage accepts a bundle this cycle
//   o_br_bus                : {br_sel, br_target} to fetch
//   i_es_allowin            : execute can accept
//   o_ds_to_es_valid/_bus   : {rd, imm, rs2_val, rs1_val, inst, pc} to execute
//   o_rf_raddr1/2, i_rf_rdata1/2 : register-file read port
//   i_es/ms/ws_dest         : {valid, rd} of downstream instructions
module ysyx_22050710_id_stage
    import ysyx_22050710_defs::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_fs_to_ds_valid,
    input  logic [FS_TO_DS_BUS_WD-1:0] i_fs_to_ds_bus,
    output logic                       o_ds_allowin,
    output logic [BR_BUS_WD-1:0]       o_br_bus,
    input  logic                       i_es_allowin,
    output logic                       o_ds_to_es_valid,
    output logic [DS_TO_ES_BUS_WD-1:0] o_ds_to_es_bus,
    output logic [4:0]                 o_rf_raddr1,
    output logic [4:0]                 o_rf_raddr2,
    input  logic [XLEN-1:0]            i_rf_rdata1,
    input  logic [XLEN-1:0]            i_rf_rdata2,
    input  logic [5:0]                 i_es_dest,
    input  logic [5:0]                 i_ms_dest,
    input  logic [5:0]                 i_ws_dest
);

    logic                ds_valid;
    logic                squash;
    logic [INST_WD-1:0]  inst;
    logic [PC_WD-1:0]    pc;
    logic [XLEN-1:0]     imm;
    logic [XLEN-1:0]     rs1_val;
    logic [XLEN-1:0]     rs2_val;
    logic [XLEN-1:0]     jalr_sum;
    logic [PC_WD-1:0]    br_target;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic                rs1_hazard;
    logic                rs2_hazard;
    logic                raw_stall;
    logic                ds_ready_go;
    logic                ds_allowin;
    logic                taken;
    logic                fire;
    logic                kill;

    function automatic logic dest_hit(input logic [5:0] dest, input logic [4:0] rs);
        return dest[5] && (dest[4:0] == rs);
    endfunction

    assign opcode  = inst[6:0];
    assign funct3  = inst[14:12];
    assign rs1     = inst[19:15];
    assign rs2     = inst[24:20];
    assign rd      = inst[11:7];
    assign rs1_val = i_rf_rdata1;
    assign rs2_val = i_rf_rdata2;

    ysyx_22050710_imm_gen u_imm_gen (
        .inst (inst),
        .imm  (imm)
    );

    always_comb begin
        rs1_hazard = rs1_used(opcode) && (rs1 != '0) &&
                     (dest_hit(i_es_dest, rs1) || dest_hit(i_ms_dest, rs1) || dest_hit(i_ws_dest, rs1));
        rs2_hazard = rs2_used(opcode) && (rs2 != '0) &&
                     (dest_hit(i_es_dest, rs2) || dest_hit(i_ms_dest, rs2) || dest_hit(i_ws_dest, rs2));
        raw_stall  = rs1_hazard || rs2_hazard;
    end

    assign ds_ready_go      = !raw_stall;
    assign ds_allowin       = !ds_valid || (ds_ready_go && i_es_allowin);
    assign o_ds_allowin     = ds_allowin;
    assign o_ds_to_es_valid = ds_valid && ds_ready_go;

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OPC_JAL, OPC_JALR: taken = 1'b1;
            OPC_BRANCH: begin
                case (funct3)
                    F3_BEQ:  taken = (rs1_val == rs2_val);
                    F3_BNE:  taken = (rs1_val != rs2_val);
                    F3_BLT:  taken = ($signed(rs1_val) <  $signed(rs2_val));
                    F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
                    F3_BLTU: taken = (rs1_val <  rs2_val);
                    F3_BGEU: taken = (rs1_val >= rs2_val);
                    default: taken = 1'b0;
                endcase
            end
            default: taken = 1'b0;
        endcase
    end

    assign jalr_sum  = rs1_val + imm;
    assign br_target = (opcode == OPC_JALR) ? {jalr_sum[PC_WD-1:1], 1'b0} : pc + imm;

    assign fire     = ds_valid && ds_ready_go && i_es_allowin && taken;
    assign kill     = fire || squash;
    assign o_br_bus = {fire, br_target};

    // squash remembers a fire that had no fetch bundle to drop; it is
    // cleared by the next accepted bundle (which kill drops), and a new fire
    // always overrides it since that fire's own kill handles any overlap.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ds_valid <= 1'b0;
            squash   <= 1'b0;
        end else begin
            if (ds_allowin) begin
                ds_valid <= i_fs_to_ds_valid && !kill;
            end
            if (fire) begin
                squash <= !i_fs_to_ds_valid;
            end else if (ds_allowin && i_fs_to_ds_valid) begin
                squash <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            inst <= '0;
            pc   <= '0;
        end else if (ds_allowin && i_fs_to_ds_valid) begin
            {inst, pc} <= i_fs_to_ds_bus;
        end
    end

    assign o_rf_raddr1    = rs1;
    assign o_rf_raddr2    = rs2;
    assign o_ds_to_es_bus = {rd, imm, rs2_val, rs1_val, inst, pc};

endmodule

// File: tb/tb_ysyx_22050710_id_stage.sv
module tb_ysyx_22050710_id_stage;
    import ysyx_22050710_defs::*;

    localparam logic [31:0] ADDI_X1  = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] ADD_X2   = 32'h0010_8133; // add  x2,x1,x1
    localparam logic [31:0] ADD_X0   = 32'h0000_0133; // add  x2,x0,x0
    localparam logic [31:0] BEQ_M16  = 32'hFE41_88E3; // beq  x3,x4,-16
    localparam logic [31:0] JALR_X5  = 32'h0042_80E7; // jalr x1,4(x5)
    localparam logic [31:0] BNE_P8   = 32'h0061_9463; // bne  x3,x6,+8
    localparam logic [31:0] BLT_P8   = 32'h0043_C463; // blt  x7,x4,+8
    localparam logic [31:0] BLTU_P8  = 32'h0043_E463; // bltu x7,x4,+8

    logic                       i_clk = 1'b0;
    logic                       i_rst;
    logic                       i_fs_to_ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0] i_fs_to_ds_bus;
    logic                       o_ds_allowin;
    logic [BR_BUS_WD-1:0]       o_br_bus;
    logic                       i_es_allowin;
    logic                       o_ds_to_es_valid;
    logic [DS_TO_ES_BUS_WD-1:0] o_ds_to_es_bus;
    logic [4:0]                 o_rf_raddr1;
    logic [4:0]                 o_rf_raddr2;
    logic [XLEN-1:0]            i_rf_rdata1;
    logic [XLEN-1:0]            i_rf_rdata2;
    logic [5:0]                 i_es_dest;
    logic [5:0]                 i_ms_dest;
    logic [5:0]                 i_ws_dest;

    logic [XLEN-1:0] regs [32];
    int unsigned     n_cmp = 0;
    int unsigned     n_err = 0;

    logic            br_sel;
    logic [63:0]     br_target;
    logic [4:0]      out_rd;
    logic [63:0]     out_imm;
    logic [63:0]     out_pc;

    assign br_sel    = o_br_bus[PC_WD];
    assign br_target = o_br_bus[PC_WD-1:0];
    assign out_pc    = o_ds_to_es_bus[PC_WD-1:0];
    assign out_imm   = o_ds_to_es_bus[DS_TO_ES_BUS_WD-6 -: 64];
    assign out_rd    = o_ds_to_es_bus[DS_TO_ES_BUS_WD-1 -: 5];

    assign i_rf_rdata1 = (o_rf_raddr1 == 5'd0) ? '0 : regs[o_rf_raddr1];
    assign i_rf_rdata2 = (o_rf_raddr2 == 5'd0) ? '0 : regs[o_rf_raddr2];

    always #5 i_clk = ~i_clk;

    ysyx_22050710_id_stage dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_fs_to_ds_valid (i_fs_to_ds_valid),
        .i_fs_to_ds_bus   (i_fs_to_ds_bus),
        .o_ds_allowin     (o_ds_allowin),
        .o_br_bus         (o_br_bus),
        .i_es_allowin     (i_es_allowin),
        .o_ds_to_es_valid (o_ds_to_es_valid),
        .o_ds_to_es_bus   (o_ds_to_es_bus),
        .o_rf_raddr1      (o_rf_raddr1),
        .o_rf_raddr2      (o_rf_raddr2),
        .i_rf_rdata1      (i_rf_rdata1),
        .i_rf_rdata2      (i_rf_rdata2),
        .i_es_dest        (i_es_dest),
        .i_ms_dest        (i_ms_dest),
        .i_ws_dest        (i_ws_dest)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [63:0] pc);
        i_fs_to_ds_valid = 1'b1;
        i_fs_to_ds_bus   = {inst, pc};
    endtask

    initial begin
        i_rst            = 1'b1;
        i_fs_to_ds_valid = 1'b0;
        i_fs_to_ds_bus   = '0;
        i_es_allowin     = 1'b1;
        i_es_dest        = '0;
        i_ms_dest        = '0;
        i_ws_dest        = '0;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        regs[3] = 64'd7;
        regs[4] = 64'd7;
        regs[5] = 64'h8000_0103;
        regs[6] = 64'd9;
        regs[7] = '1;

        // reset state
        tick();
        tick();
        check_eq("rst_valid",   64'(o_ds_to_es_valid), 64'd0);
        check_eq("rst_allowin", 64'(o_ds_allowin),     64'd1);
        check_eq("rst_br_sel",  64'(br_sel),           64'd0);
        check_eq("rst_pc",      out_pc,                64'd0);
        i_rst = 1'b0;

        // single issue
        offer(ADDI_X1, 64'h8000_0000);
        tick();
        i_fs_to_ds_valid = 1'b0;
        #1;
        check_eq("addi_valid", 64'(o_ds_to_es_valid), 64'd1);
        check_eq("addi_imm",   out_imm,                64'd5);
        check_eq("addi_rd",    64'(out_rd),            64'd1);
        check_eq("addi_ra1",   64'(o_rf_raddr1),       64'd0);
        check_eq("addi_pc",    out_pc,                 64'h8000_0000);

        // RAW stall against EX
        i_es_dest = {1'b1, 5'd1};
        offer(ADD_X2, 64'h8000_0004);
        tick();
        i_fs_to_ds_valid = 1'b0;
        #1;
        check_eq("raw_es_allowin", 64'(o_ds_allowin),     64'd0);
        check_eq("raw_es_valid",   64'(o_ds_to_es_valid), 64'd0);
        check_eq("raw_es_imm_r",   out_imm,               64'd0);
        tick();
        check_eq("raw_es_hold_v",  64'(o_ds_to_es_valid), 64'd0);
        check_eq("raw_es_hold_pc", out_pc,                64'h8000_0004);
        i_es_dest = '0;
        #1;
        check_eq("raw_es_release", 64'(o_ds_to_es_valid), 64'd1);
        check_eq("raw_es_allow2",  64'(o_ds_allowin),     64'd1);
        tick();
        check_eq("raw_es_drained", 64'(o_ds_to_es_valid), 64'd0);

        // RAW stall against MEM, then WB
        for (int s = 0; s < 2; s++) begin
            if (s == 0) i_ms_dest = {1'b1, 5'd1};
            else        i_ws_dest = {1'b1, 5'd1};
            offer(ADD_X2, 64'h8000_0008);
            tick();
            i_fs_to_ds_valid = 1'b0;
            #1;
            check_eq((s == 0) ? "raw_ms_valid" : "raw_ws_valid", 64'(o_ds_to_es_valid), 64'd0);
            i_ms_dest = '0;
            i_ws_dest = '0;
            #1;
            check_eq((s == 0) ? "raw_ms_release" : "raw_ws_release", 64'(o_ds_to_es_valid), 64'd1);
            tick();
        end

        // x0 never interlocks
        i_es_dest = {1'b1, 5'd0};
        offer(ADD_X0, 64'h8000_000C);
        tick();
        i_fs_to_ds_valid = 1'b0;
        #1;
        check_eq("x0_valid", 64'(o_ds_to_es_valid), 64'd1);
        tick();
        // I-type does not read its rs2 field (here 5)
        i_es_dest = {1'b1, 5'd5};
        offer(ADDI_X1, 64'h8000_0010);
        tick();
        i_fs_to_ds_valid = 1'b0;
        #1;
        check_eq("rs2_unused_valid", 64'(o_ds_to_es_valid), 64'd1);
        tick();
        i_es_dest = '0;

        // signed vs unsigned compare: x7=-1, x4=7
        offer(BLTU_P8, 64'h8000_0030);
        tick();
        i_fs_to_ds_valid = 1'b0;
        #1;
        check_eq("bltu_br_sel", 64'(br_sel), 64'd0);
        check_eq("bltu_imm",    out_imm,     64'd8);
        tick();
        offer(BLT_P8, 64'h8000_0040);
        tick();
        i_fs_to_ds_valid = 1'b0;
        #1;
        check_eq("blt_br_sel", 64'(br_sel), 64'd1);
        check_eq("blt_target", br_target,   64'h8000_0048);
        tick();
        offer(ADDI_X1, 64'h8000_0044);
        tick();
        i_fs_to_ds_valid = 1'b0;
        #1;
        check_eq("blt_squash_drop", 64'(o_ds_to_es_valid), 64'd0);

        // taken BEQ with wrong-path bundle at the fire edge
        offer(BEQ_M16, 64'h8000_0010);
        tick();
        offer(ADDI_X1, 64'h8000_0014);
        #1;
        check_eq("beq_br_sel", 64'(br_sel), 64'd1);
        check_eq("beq_target", br_target,   64'h8000_0000);
        tick();
        i_fs_to_ds_valid = 1'b0;
        #1;
        check_eq("beq_kill_valid", 64'(o_ds_to_es_valid), 64'd0);
        check_eq("beq_one_shot",   64'(br_sel),           64'd0);
        offer(ADDI_X1, 64'h8000_0000);
        tick();
        i_fs_to_ds_valid = 1'b0;
        #1;
        check_eq("beq_next_valid", 64'(o_ds_to_es_valid), 64'd1);
        check_eq("beq_next_pc",    out_pc,                64'h8000_0000);
        tick();

        // JALR with fetch bubble at fire
        offer(JALR_X5, 64'h8000_0050);
        tick();
        i_fs_to_ds_valid = 1'b0;
        #1;
        check_eq("jalr_br_sel", 64'(br_sel),  64'd1);
        check_eq("jalr_target", br_target,    64'h8000_0106);
        check_eq("jalr_rd",     64'(out_rd),  64'd1);
        tick();
        check_eq("jalr_bubble", 64'(o_ds_to_es_valid), 64'd0);
        offer(ADDI_X1, 64'h8000_0054);
        tick();
        offer(ADDI_X1, 64'h8000_0106);
        #1;
        check_eq("jalr_drop", 64'(o_ds_to_es_valid), 64'd0);
        tick();
        i_fs_to_ds_valid = 1'b0;
        #1;
        check_eq("jalr_issue_v",  64'(o_ds_to_es_valid), 64'd1);
        check_eq("jalr_issue_pc", out_pc,                64'h8000_0106);
        tick();

        // back-pressure on a taken BNE
        i_es_allowin = 1'b0;
        offer(BNE_P8, 64'h8000_0020);
        tick();
        i_fs_to_ds_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq("bp_br_sel",  64'(br_sel),       64'd0);
            check_eq("bp_allowin", 64'(o_ds_allowin), 64'd0);
            tick();
        end
        i_es_allowin = 1'b1;
        #1;
        check_eq("bp_fire",   64'(br_sel), 64'd1);
        check_eq("bp_target", br_target,   64'h8000_0028);
        tick();
        check_eq("bp_one_shot", 64'(br_sel), 64'd0);
        offer(ADDI_X1, 64'h8000_0024);
        tick();
        i_fs_to_ds_valid = 1'b0;

        // mid-operation reset while held
        i_es_allowin = 1'b0;
        offer(BNE_P8, 64'h8000_0060);
        tick();
        i_fs_to_ds_valid = 1'b0;
        #1;
        check_eq("mrst_pre_valid", 64'(o_ds_to_es_valid), 64'd1);
        #2;
        i_rst = 1'b1;
        #1;
        check_eq("mrst_valid",   64'(o_ds_to_es_valid), 64'd0);
        check_eq("mrst_allowin", 64'(o_ds_allowin),     64'd1);
        check_eq("mrst_br_sel",  64'(br_sel),           64'd0);
        check_eq("mrst_pc",      out_pc,                64'd0);
        tick();
        i_rst = 1'b0;
        i_es_allowin = 1'b1;
        #1;
        check_eq("mrst_after_v",  64'(o_ds_to_es_valid), 64'd0);
        check_eq("mrst_after_br", 64'(br_sel),           64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
